// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and latency constants for the multiply/divide unit.
// Operation codes, FSM states and the helper that splits the two latency classes.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_MULTU = 3'b000,
      MD_MULT  = 3'b001,
      MD_DIVU  = 3'b010,
      MD_DIV   = 3'b011,
      MD_MADD  = 3'b100,
      MD_MSUB  = 3'b101,
      MD_MADDU = 3'b110,
      MD_MSUBU = 3'b111
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;
   localparam int CNT_W       = 4;

   function automatic logic is_div(input md_op_e op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

   function automatic logic is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
   endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational 64-bit result for every MDOp from latched operands and latched {HI,LO}.
// Division works on magnitudes so 0x80000000 / -1 falls out without a special case.
module md_compute
   import mult_div_unit_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   input  logic [63:0] acc,
   output logic [63:0] result
);

   md_op_e      op_e;
   logic        sgn;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   // NOTE: every signal gets a value on every path before the case below, so no latch is inferred.
   always_comb begin
      op_e  = md_op_e'(op);
      sgn   = is_signed(op_e);
      a_ext = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      b_ext = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      prod  = a_ext * b_ext;

      a_mag = (sgn && a[31]) ? -a : a;
      b_mag = (sgn && b[31]) ? -b : b;
      q_mag = 32'd0;
      r_mag = 32'd0;
      if (b_mag != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      quo = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
      rem = (sgn && a[31]) ? -r_mag : r_mag;

      result = acc;
      case (op_e)
         MD_MULTU, MD_MULT: result = prod;
         MD_MADD, MD_MADDU: result = acc + prod;
         MD_MSUB, MD_MSUBU: result = acc - prod;
         MD_DIVU, MD_DIV: begin
            if (b != 32'd0) result = {rem, quo};
         end
         default: result = acc;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: IDLE/RUN FSM with a latency down-counter.
// Operands are captured at start; the result is written to HI/LO when the count expires.
module mult_div_unit
   import mult_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDOp,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [63:0]      acc_q, acc_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             busy_q, busy_d;
   logic [63:0]      result;

   md_compute u_compute (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .acc    (acc_q),
      .result (result)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;

      case (state_q)
         ST_IDLE: begin
            // start has priority; a coincident move is dropped.
            if (start) begin
               a_d     = A;
               b_d     = B;
               op_d    = MDOp;
               acc_d   = {hi_q, lo_q};
               cnt_d   = is_div(md_op_e'(MDOp)) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               if (mthi) hi_d = A;
               if (mtlo) lo_d = A;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               hi_d    = result[63:32];
               lo_d    = result[31:0];
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign HI   = hi_q;
   assign LO   = lo_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  MDOp  = 3'd0;
   logic        mthi  = 1'b0;
   logic        mtlo  = 1'b0;
   logic [31:0] A     = 32'd0;
   logic [31:0] B     = 32'd0;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] hi_m    = 32'd0;
   logic [31:0] lo_m    = 32'd0;

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .MDOp  (MDOp),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .A     (A),
      .B     (B),
      .HI    (HI),
      .LO    (LO),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural meaning of each opcode, written with native 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      longint          sa, sb;
      longint unsigned ua, ub, acc;
      logic [63:0]     r;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = 64'(a);
      ub  = 64'(b);
      acc = {hi, lo};
      r   = acc;
      case (op)
         3'b000: r = ua * ub;
         3'b001: r = 64'(sa * sb);
         3'b010: if (b != 0) r = {a % b, a / b};
         3'b011: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
         3'b100: r = acc + 64'(sa * sb);
         3'b110: r = acc + ua * ub;
         3'b101: r = acc - 64'(sa * sb);
         3'b111: r = acc - ua * ub;
         default: r = acc;
      endcase
      return r;
   endfunction

   task automatic mv(input bit h, input bit l, input logic [31:0] val);
      mthi = h;
      mtlo = l;
      A    = val;
      tick();
      mthi = 1'b0;
      mtlo = 1'b0;
      if (h) hi_m = val;
      if (l) lo_m = val;
      check("move", {HI, LO}, {hi_m, lo_m});
   endtask

   // Launch one op, watch busy, confirm HI/LO hold, then compare the result.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input bit with_move);
      logic [63:0] exp;
      int          n;
      int          cyc;
      exp   = model(op, a, b, hi_m, lo_m);
      cyc   = (op == 3'b010 || op == 3'b011) ? 10 : 5;
      start = 1'b1;
      MDOp  = op;
      A     = a;
      B     = b;
      mthi  = with_move;
      mtlo  = with_move;
      tick();
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      A     = $urandom;
      B     = $urandom;
      MDOp  = 3'($urandom_range(0, 7));
      n     = 0;
      while (busy && n < 20) begin
         check("hold", {HI, LO}, {hi_m, lo_m});
         if (poke && n == 1) begin
            start = 1'b1;
            mthi  = 1'b1;
            mtlo  = 1'b1;
         end else begin
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      check("busy_cycles", 64'(n), 64'(cyc));
      hi_m = exp[63:32];
      lo_m = exp[31:0];
      check("result", {HI, LO}, exp);
      if (poke) begin
         tick();
         check("busy_after", {63'd0, busy}, 64'd0);
         check("hilo_after", {HI, LO}, {hi_m, lo_m});
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1 reset = 1'b0;
      #2;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);
      tick();
      tick();
      reset = 1'b1;

      do_op(3'b001, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      check("req_mult", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(3'b010, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
      check("req_divu", {HI, LO}, 64'h0000_000F_0FFF_FFFF);
      do_op(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      check("req_div", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

      mv(1'b1, 1'b0, 32'd0);
      mv(1'b0, 1'b1, 32'd5);
      do_op(3'b100, 32'd2, 32'd3, 1'b0, 1'b0);
      check("req_madd", {HI, LO}, 64'h0000_0000_0000_000B);
      do_op(3'b101, 32'd1, 32'd12, 1'b0, 1'b0);
      check("req_msub", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

      do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("req_div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

      mv(1'b1, 1'b0, 32'h1234);
      mv(1'b0, 1'b1, 32'h5678);
      do_op(3'b011, 32'd99, 32'd0, 1'b0, 1'b0);
      check("req_div0", {HI, LO}, 64'h0000_1234_0000_5678);

      // start with a coincident move, then start/moves while busy
      do_op(3'b110, 32'd3, 32'd4, 1'b0, 1'b1);
      do_op(3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);

      // reset in RUN cycle 3 of a div
      mv(1'b1, 1'b1, 32'h1111_2222);
      start = 1'b1;
      MDOp  = 3'b011;
      A     = 32'd100;
      B     = 32'd7;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_hilo", {HI, LO}, 64'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("post_rst", {31'd0, busy, HI}, {31'd0, 1'b0, 32'd0});
         check("post_rst_lo", {32'd0, LO}, 64'd0);
      end

      mv(1'b1, 1'b1, 32'h0BAD_F00D);
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      hi_m = 32'd0;
      lo_m = 32'd0;
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            mv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         do_op(3'($urandom_range(0, 7)), pick(), pick(),
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
